// File: rtl/lsu_bus_if.sv
// Data bus between the load/store unit (master) and memory (slave).
// The request phase is req/gnt; the response phase is rvalid, returned for writes too.
interface lsu_bus_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_bus.sv
// Load/store unit: turns one mem_ctrl op into a single req/gnt/rvalid bus access and
// stalls the core until it completes, is rejected as misaligned, or times out.
`ifndef MEM_NONE
`define MEM_NONE   4'd0
`endif
`ifndef MEM_LOAD1
`define MEM_LOAD1  4'd1
`endif
`ifndef MEM_LOAD2
`define MEM_LOAD2  4'd2
`endif
`ifndef MEM_LOAD4
`define MEM_LOAD4  4'd3
`endif
`ifndef MEM_LOAD1U
`define MEM_LOAD1U 4'd4
`endif
`ifndef MEM_LOAD2U
`define MEM_LOAD2U 4'd5
`endif
`ifndef MEM_STORE1
`define MEM_STORE1 4'd6
`endif
`ifndef MEM_STORE2
`define MEM_STORE2 4'd7
`endif
`ifndef MEM_STORE4
`define MEM_STORE4 4'd8
`endif

module lsu_bus #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o,
    lsu_bus_if.master   bus
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    off_q, off_d;
    logic [3:0]    op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          misalign_q, misalign_d;
    logic          bus_err_q, bus_err_d;

    logic          op_valid;
    logic          is_store;
    logic          misaligned;
    logic [1:0]    size;
    logic [3:0]    be_new;
    logic [31:0]   wdata_new;
    logic          req;

    // Shift the addressed lane down to bit 0, then extend according to the latched op.
    function automatic logic [31:0] fmt_load(input logic [3:0] op, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (op)
            `MEM_LOAD1:  fmt_load = {{24{sh[7]}}, sh[7:0]};
            `MEM_LOAD1U: fmt_load = {24'd0, sh[7:0]};
            `MEM_LOAD2:  fmt_load = {{16{sh[15]}}, sh[15:0]};
            `MEM_LOAD2U: fmt_load = {16'd0, sh[15:0]};
            default:     fmt_load = sh;
        endcase
    endfunction

    assign op_valid = (mem_ctrl != `MEM_NONE);

    // size: 0 = byte, 1 = halfword, 2 = word
    always_comb begin
        is_store  = 1'b0;
        size      = 2'd2;
        be_new    = 4'b1111;
        wdata_new = '0;
        case (mem_ctrl)
            `MEM_LOAD1, `MEM_LOAD1U: size = 2'd0;
            `MEM_LOAD2, `MEM_LOAD2U: size = 2'd1;
            `MEM_STORE1: begin
                size     = 2'd0;
                is_store = 1'b1;
            end
            `MEM_STORE2: begin
                size     = 2'd1;
                is_store = 1'b1;
            end
            `MEM_STORE4: is_store = 1'b1;
            default:     size = 2'd2;
        endcase
        misaligned = ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'b00));
        if (is_store) begin
            case (size)
                2'd0: begin
                    be_new    = 4'b0001 << addr[1:0];
                    wdata_new = {4{wdata_i[7:0]}};
                end
                2'd1: begin
                    be_new    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_new = {2{wdata_i[15:0]}};
                end
                default: wdata_new = wdata_i;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        be_d       = be_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        off_d      = off_q;
        op_d       = op_q;
        cnt_d      = '0;
        rdata_d    = rdata_q;
        misalign_d = 1'b0;
        bus_err_d  = 1'b0;
        stall_o    = 1'b0;
        req        = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_o = op_valid;
                if (op_valid) begin
                    if (misaligned) begin
                        state_d    = S_DONE;
                        misalign_d = 1'b1;
                        rdata_d    = '0;
                    end else begin
                        state_d = S_REQ;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = be_new;
                        we_d    = is_store;
                        wdata_d = wdata_new;
                        off_d   = addr[1:0];
                        op_d    = mem_ctrl;
                    end
                end
            end
            S_REQ: begin
                stall_o = 1'b1;
                req     = 1'b1;
                if (bus.bus_gnt) begin
                    if (bus.bus_rvalid) begin
                        state_d = S_DONE;
                        rdata_d = fmt_load(op_q, off_q, bus.bus_rdata);
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                // A response arriving in the last allowed cycle wins over the timeout.
                if (bus.bus_rvalid) begin
                    state_d = S_DONE;
                    rdata_d = fmt_load(op_q, off_q, bus.bus_rdata);
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d   = S_DONE;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            off_q      <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            off_q      <= off_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus.bus_req   = req;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
    assign rdata_o       = rdata_q;
    assign misalign_o    = misalign_q;
    assign bus_err_o     = bus_err_q;

endmodule
